// File: rtl/ccm_ctr_sched.sv
// CCM counter-mode sequencer: packs byte-serial payload into 128-bit blocks,
// requests a keystream block per counter value and streams payload XOR keystream.
module ccm_ctr_sched #(
  parameter int WIDTH       = 8,
  parameter int WIDTH_NONCE = 100,
  parameter int WIDTH_FLAG  = 8,
  parameter int WIDTH_COUNT = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       input_data,
  input  logic                   input_en,
  input  logic                   input_last,
  output logic                   input_ready,
  input  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce,
  input  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag,
  output logic                   aes_start,
  output logic [127:0]           aes_block,
  input  logic                   aes_done,
  input  logic [127:0]           aes_result,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_en,
  output logic                   busy,
  output logic                   ctr_overflow
);

  localparam int NBYTES = 128 / WIDTH;
  localparam int IW     = $clog2(NBYTES);

  localparam logic [IW-1:0]          IDX_ONE   = IW'(1);
  localparam logic [IW-1:0]          IDX_MAX   = IW'(NBYTES - 1);
  localparam logic [WIDTH_COUNT-1:0] COUNT_ONE = WIDTH_COUNT'(1);

  typedef enum logic [2:0] {IDLE, FILL, REQ, WAIT, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [127:0]           data_q, data_d;
  logic [127:0]           ks_q, ks_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   last_q, last_d;
  logic [WIDTH_NONCE-1:0] nonce_q, nonce_d;
  logic [WIDTH_FLAG-1:0]  flag_q, flag_d;
  logic [WIDTH_COUNT-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;

  // Byte 0 of a block occupies the most significant lane.
  function automatic int lane_lsb(input logic [IW-1:0] idx);
    return (NBYTES - 1 - int'(idx)) * WIDTH;
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    data_d  = data_q;
    ks_d    = ks_q;
    idx_d   = idx_q;
    last_d  = last_q;
    nonce_d = nonce_q;
    flag_d  = flag_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (input_en) begin
          nonce_d = ccm_ctr_nonce;
          flag_d  = ccm_ctr_flag;
          ovf_d   = 1'b0;
          count_d = COUNT_ONE;
          data_d  = '0;
          data_d[lane_lsb('0) +: WIDTH] = input_data;
          last_d  = input_last;
          idx_d   = input_last ? '0 : IDX_ONE;
          state_d = input_last ? REQ : FILL;
        end
      end
      FILL: begin
        if (input_en) begin
          data_d[lane_lsb(idx_q) +: WIDTH] = input_data;
          idx_d = idx_q + IDX_ONE;
          if (input_last || idx_q == IDX_MAX) begin
            idx_d   = '0;
            last_d  = input_last;
            state_d = REQ;
          end
        end else if (input_last) begin
          // An empty block after an exactly-full one needs no keystream.
          if (idx_q == '0) begin
            count_d = COUNT_ONE;
            state_d = IDLE;
          end else begin
            idx_d   = '0;
            last_d  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (aes_done) begin
          ks_d    = aes_result;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        idx_d = idx_q + IDX_ONE;
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
          if (last_q) begin
            count_d = COUNT_ONE;
            state_d = IDLE;
          end else begin
            data_d  = '0;
            count_d = count_q + COUNT_ONE;
            if (&count_q) ovf_d = 1'b1;
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the block buffers are reset too, so unfilled lanes are zero padding
  // and no stale payload of an abandoned message can ever reach the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      ks_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      nonce_q <= '0;
      flag_q  <= '0;
      count_q <= COUNT_ONE;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      data_q  <= data_d;
      ks_q    <= ks_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      nonce_q <= nonce_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode straight from state so a reset drops them without a clock.
  assign input_ready  = (state_q == IDLE) || (state_q == FILL);
  assign busy         = (state_q != IDLE);
  assign aes_start    = (state_q == REQ);
  assign aes_block    = (state_q == REQ || state_q == WAIT) ? {flag_q, nonce_q, count_q} : '0;
  assign out_en       = (state_q == DRAIN);
  assign out_data     = (state_q == DRAIN) ?
                        (data_q[lane_lsb(idx_q) +: WIDTH] ^ ks_q[lane_lsb(idx_q) +: WIDTH]) : '0;
  assign ctr_overflow = ovf_q;

endmodule

// File: tb/tb_ccm_ctr_sched.sv
// Directed bench for ccm_ctr_sched with a 4-bit counter so the wrap is reachable.
module tb_ccm_ctr_sched;

  localparam int WN    = 116;
  localparam int WF    = 8;
  localparam int WC    = 4;
  localparam int LIMIT = 400;
  localparam logic [127:0] KS = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     input_data;
  logic           input_en, input_last, input_ready;
  logic [WN-1:0]  ccm_ctr_nonce;
  logic [WF-1:0]  ccm_ctr_flag;
  logic           aes_start, aes_done;
  logic [127:0]   aes_block, aes_result;
  logic [7:0]     out_data;
  logic           out_en, busy, ctr_overflow;

  logic           model_done, model_busy, spur_done;
  logic [3:0]     model_cnt;
  assign aes_done = model_done | spur_done;

  always #5 clk = ~clk;

  ccm_ctr_sched #(.WIDTH(8), .WIDTH_NONCE(WN), .WIDTH_FLAG(WF), .WIDTH_COUNT(WC)) dut (
    .clk(clk), .reset(reset),
    .input_data(input_data), .input_en(input_en), .input_last(input_last),
    .input_ready(input_ready),
    .ccm_ctr_nonce(ccm_ctr_nonce), .ccm_ctr_flag(ccm_ctr_flag),
    .aes_start(aes_start), .aes_block(aes_block),
    .aes_done(aes_done), .aes_result(aes_result),
    .out_data(out_data), .out_en(out_en), .busy(busy), .ctr_overflow(ctr_overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc;
  int done_cyc;

  byte unsigned   msg[$];
  logic [127:0]   st_blk[$];
  logic           st_ovf[$];
  int             st_cyc[$];
  logic [127:0]   done_blk[$];
  byte unsigned   out_q[$];
  int             out_cyc[$];
  logic [WN-1:0]  exp_nonce;
  logic [WF-1:0]  exp_flag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ks_for(input logic [3:0] c);
    return KS ^ {32{c}};
  endfunction

  // AES stand-in: keystream depends on the requested counter, done 5 cycles after start.
  initial begin
    model_done = 1'b0; model_busy = 1'b0; aes_result = '0; model_cnt = '0;
    forever begin
      @(negedge clk);
      if (aes_start === 1'b1) begin
        model_busy = 1'b1;
        model_cnt  = aes_block[3:0];
        repeat (5) @(posedge clk);
        #1 model_done = 1'b1; aes_result = ks_for(model_cnt);
        @(posedge clk);
        #1 model_done = 1'b0; model_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (aes_start === 1'b1) begin
      st_blk.push_back(aes_block); st_ovf.push_back(ctr_overflow); st_cyc.push_back(cyc);
    end
    if (model_done) begin
      done_cyc <= cyc; done_blk.push_back(aes_block);
    end
    if (out_en === 1'b1) begin
      out_q.push_back(out_data); out_cyc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    st_blk.delete(); st_ovf.delete(); st_cyc.delete(); done_blk.delete();
    out_q.delete(); out_cyc.delete();
  endtask

  task automatic load(input int n, input int mul, input int add);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'(i * mul + add));
  endtask

  task automatic set_ids(input logic [7:0] f, input logic [31:0] s);
    exp_flag      = f;
    exp_nonce     = WN'({s, ~s, s ^ 32'h5A5A5A5A, s + 32'd1});
    ccm_ctr_flag  = exp_flag;
    ccm_ctr_nonce = exp_nonce;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (input_ready !== 1'b1 && k < LIMIT) begin @(posedge clk); #1; k++; end
    if (k >= LIMIT) check("ready_timeout", k, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy !== 1'b0 || model_busy) && k < LIMIT) begin @(posedge clk); #1; k++; end
    if (k >= LIMIT) check("idle_timeout", k, 0);
  endtask

  // Drives msg[lo..hi-1] back to back; nonce/flag are scrambled once byte 0 is taken.
  task automatic send(input int lo, input int hi, input bit last_on_end);
    for (int i = lo; i < hi; i++) begin
      wait_ready();
      input_en   = 1'b1;
      input_data = msg[i];
      input_last = last_on_end && (i == hi - 1);
      last_cyc   = cyc;
      @(posedge clk); #1;
      input_en   = 1'b0;
      input_last = 1'b0;
      if (i == 0) begin ccm_ctr_nonce = ~exp_nonce; ccm_ctr_flag = ~exp_flag; end
    end
  endtask

  task automatic check_outputs(input string tag, input int n);
    int nblk;
    logic [127:0] eb, ob, ks;
    logic [3:0] c;
    byte unsigned d;
    nblk = (n + 15) / 16;
    check({tag, "_nreq"}, st_blk.size(), nblk);
    check({tag, "_nout"}, out_q.size(), nblk * 16);
    for (int b = 0; b < nblk && b < st_blk.size() && b < done_blk.size(); b++) begin
      c  = 4'((b + 1) % 16);
      ks = ks_for(c);
      check($sformatf("%s_cnt%0d", tag, b), st_blk[b][3:0], c);
      check($sformatf("%s_id%0d", tag, b), st_blk[b][127:4], {exp_flag, exp_nonce});
      check($sformatf("%s_ovf%0d", tag, b), st_ovf[b], b >= 15);
      check($sformatf("%s_hold%0d", tag, b), done_blk[b], st_blk[b]);
      eb = '0; ob = '0;
      for (int j = 0; j < 16; j++) begin
        d = (16 * b + j < n) ? msg[16 * b + j] : 8'h00;
        eb[127 - 8 * j -: 8] = d ^ ks[127 - 8 * j -: 8];
        if (16 * b + j < out_q.size()) ob[127 - 8 * j -: 8] = out_q[16 * b + j];
      end
      check($sformatf("%s_data%0d", tag, b), ob, eb);
    end
  endtask

  initial begin
    bit rdy_seen;
    int k;
    reset = 1'b0; input_en = 1'b0; input_last = 1'b0; input_data = '0; spur_done = 1'b0;
    set_ids(8'h00, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", input_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_start", aes_start, 1'b0);
    check("rst_block", aes_block, '0);
    check("rst_out", {out_en, out_data}, 9'h0);
    check("rst_ovf", ctr_overflow, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // input_last alone in IDLE is ignored
    input_last = 1'b1;
    @(posedge clk); #1;
    input_last = 1'b0;
    check("idle_last_busy", busy, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("idle_last_nreq", st_blk.size(), 0);

    // one full block, latency and handshake timing
    clear_mon(); load(16, 1, 0); set_ids(8'h59, 32'hC0FFEE01);
    send(0, 16, 1);
    wait_idle();
    check_outputs("t1", 16);
    check("t1_start_lat", st_cyc.size() > 0 ? st_cyc[0] : -1, last_cyc + 1);
    check("t1_out_lat", out_cyc.size() > 0 ? out_cyc[0] : -1, done_cyc + 1);
    check("t1_out_run", out_cyc.size() == 16 ? out_cyc[15] - out_cyc[0] : -1, 15);
    check("t1_busy", busy, 1'b0);
    check("t1_ready", input_ready, 1'b1);

    // partial second block is zero padded
    clear_mon(); load(20, 1, 8'h30); set_ids(8'h41, 32'h12345678);
    send(0, 20, 1);
    wait_idle();
    check_outputs("t2", 20);

    // exactly two full blocks, then input_last alone
    clear_mon(); load(32, 7, 1); set_ids(8'h7E, 32'hDEADBEEF);
    send(0, 32, 0);
    wait_ready();
    input_last = 1'b1;
    @(posedge clk); #1;
    input_last = 1'b0;
    check("t3_idle", busy, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk); #1;
    check_outputs("t3", 32);

    // sixteen blocks wrap the 4-bit counter
    clear_mon(); load(256, 3, 8'h5A); set_ids(8'h13, 32'h0BADF00D);
    send(0, 256, 1);
    wait_idle();
    check_outputs("t4", 256);
    check("t4_ovf_sticky", ctr_overflow, 1'b1);

    // ignored inputs: stray aes_done in FILL, bytes while not ready
    clear_mon(); load(16, 1, 8'hC0); set_ids(8'hA2, 32'h55AA33CC);
    send(0, 1, 0);
    check("t5_ovf_clear", ctr_overflow, 1'b0);
    send(1, 8, 0);
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    check("t5_spur_fill", {busy, input_ready}, 2'b11);
    send(8, 16, 1);
    rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      input_en = 1'b1; input_data = 8'hA5;
      rdy_seen |= input_ready;
      @(posedge clk); #1;
    end
    input_en = 1'b0;
    check("t5_not_ready", rdy_seen, 1'b0);
    wait_idle();
    check_outputs("t5", 16);

    // reset in the 7th drain cycle
    clear_mon(); load(16, 5, 9); set_ids(8'h66, 32'h31415926);
    send(0, 16, 1);
    k = 0;
    while (out_en !== 1'b1 && k < LIMIT) begin @(posedge clk); #1; k++; end
    if (k >= LIMIT) check("t6_out_timeout", k, 0);
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_out", {out_en, out_data}, 9'h0);
    check("t6_rst_state", {busy, input_ready, aes_start, ctr_overflow}, 4'b0100);
    check("t6_rst_block", aes_block, '0);
    check("t6_partial", out_q.size(), 6);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    clear_mon(); load(16, 11, 2); set_ids(8'h99, 32'h27182818);
    send(0, 16, 1);
    wait_idle();
    check_outputs("t6", 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
